// File: rtl/boot_stream_loader.sv
// boot_stream_loader
//   Feeds the CPU boot port from a byte stream. The stream is a one-byte word
//   count N, then N big-endian 32-bit words, then an XOR checksum byte covering
//   the count and every data byte. Each assembled word is written with a
//   single-cycle active-low strobe. The CPU is held in boot until the image
//   checks out.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         begin a load (honoured only when idle, done or in error)
//   in_valid      in_data carries a byte
//   in_data       stream byte
//   in_ready      a byte can be accepted this cycle
//   boot_up       CPU held in boot mode
//   boot_addr     instruction memory word address (BASE_ADDR + word index)
//   boot_datai    instruction word
//   boot_web      active-low write strobe, one cycle per word
//   done          level: load completed with a good checksum
//   err           level: load failed
//   err_code      01 checksum, 10 zero length, 11 timeout, 00 otherwise
module boot_stream_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              boot_up,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [31:0]       boot_datai,
  output logic              boot_web,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    n_words;
  logic [7:0]    word_idx;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_buf;
  logic [7:0]    csum;
  logic [TW-1:0] tmo_cnt;

  logic running, accept, tmo_hit, start_ok, last_word;

  always_comb begin
    running   = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    accept    = in_valid && running;
    // Expires on the TIMEOUT-th consecutive idle cycle; an accept that same
    // cycle still wins.
    tmo_hit   = running && !accept && (tmo_cnt == TW'(TIMEOUT - 1));
    start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    last_word = (word_idx + 8'd1) == n_words;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_HDR;
      S_HDR: begin
        if (accept)       state_nxt = (in_data == '0) ? S_ERR : S_DATA;
        else if (tmo_hit) state_nxt = S_ERR;
      end
      S_DATA: begin
        if (accept) begin
          if (byte_cnt == 2'd3) state_nxt = S_WRITE;
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_WRITE: state_nxt = last_word ? S_CSUM : S_DATA;
      S_CSUM: begin
        if (accept)       state_nxt = (in_data == csum) ? S_DONE : S_ERR;
        else if (tmo_hit) state_nxt = S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = running;
    boot_web = (state != S_WRITE);
    boot_up  = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);
    err      = (state == S_ERR);
  end

  // Datapath: counters, checksum, word assembly and write registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_words    <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      boot_addr  <= '0;
      boot_datai <= '0;
      err_code   <= '0;
    end else begin
      // Zero outside the running states, so entry to HDR starts from zero.
      tmo_cnt <= (running && !accept) ? tmo_cnt + TW'(1) : '0;

      if (start_ok) begin
        csum     <= '0;
        err_code <= '0;
      end

      if (accept && (state != S_CSUM)) csum <= csum ^ in_data;

      if ((state == S_HDR) && accept) begin
        n_words  <= in_data;
        word_idx <= '0;
        byte_cnt <= '0;
      end

      if ((state == S_DATA) && accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        word_buf <= {word_buf[15:0], in_data};
        if (byte_cnt == 2'd3) begin
          // Loaded one cycle early so the values are stable for the whole
          // WRITE strobe and then hold afterwards.
          boot_datai <= {word_buf, in_data};
          boot_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);
        end
      end

      if (state == S_WRITE) word_idx <= word_idx + 8'd1;

      if ((state_nxt == S_ERR) && (state != S_ERR)) begin
        if (tmo_hit)             err_code <= 2'b11;
        else if (state == S_HDR) err_code <= 2'b10;
        else                     err_code <= 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_boot_stream_loader.sv
module tb_boot_stream_loader;
  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int TIMEOUT   = 1023;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, boot_up, boot_web, done, err;
  logic [ADDR_W-1:0] boot_addr;
  logic [31:0]       boot_datai;
  logic [1:0]        err_code;

  boot_stream_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .boot_up   (boot_up),
    .boot_addr (boot_addr),
    .boot_datai(boot_datai),
    .boot_web  (boot_web),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int         total = 0;
  int         bad   = 0;
  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] stim_q[$];
  logic       exp_done;
  logic [1:0] exp_code;

  // Write monitor: every low strobe is one word; in_ready must be low then.
  always @(negedge clk) begin
    if (!rst && boot_web === 1'b0) begin
      got_q.push_back({boot_addr, boot_datai});
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL write_ready got=%b need=0", in_ready);
      end
    end
  end

  // Random image of n words with a good or deliberately corrupted checksum.
  function automatic void gen_stream(input int n, input bit good);
    logic [7:0] x, b;
    stim_q.delete();
    stim_q.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stim_q.push_back(b);
      x ^= b;
    end
    stim_q.push_back(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
  endfunction

  // Reference: what a complete stream must produce.
  function automatic void build_expect();
    int         n;
    logic [7:0] x;
    wr_t        w;
    exp_q.delete();
    n = int'(stim_q[0]);
    if (n == 0) begin
      exp_done = 1'b0;
      exp_code = 2'b10;
      return;
    end
    x = '0;
    for (int i = 0; i <= 4 * n; i++) x ^= stim_q[i];
    for (int k = 0; k < n; k++) begin
      w.addr = ADDR_W'(BASE_ADDR + k);
      w.data = {stim_q[4*k+1], stim_q[4*k+2], stim_q[4*k+3], stim_q[4*k+4]};
      exp_q.push_back(w);
    end
    exp_done = (stim_q[4*n+1] == x);
    exp_code = exp_done ? 2'b00 : 2'b01;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_ready got=%b need=1", in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(stim_q[i], 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    start = 1'b1;  // reset must win over start
    @(negedge clk);
    total++;
    if ({in_ready, boot_up, boot_web, done, err, err_code} !== 7'b0010000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b need=0010000",
               {in_ready, boot_up, boot_web, done, err, err_code});
    end
    total++;
    if ({boot_addr, boot_datai} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h need=0", {boot_addr, boot_datai});
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    stim_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    build_expect();
    got_q.delete();
    pulse_start();
    total++;
    if ({boot_up, in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL normal_hdr got=%b need=11", {boot_up, in_ready});
    end
    send_range(0, 4);
    total++;
    if ({boot_web, in_ready, boot_addr, boot_datai} !== {2'b00, 8'h00, 32'h11223344}) begin
      bad++;
      $display("FAIL normal_first_write got=%h need=%h",
               {boot_web, in_ready, boot_addr, boot_datai}, {2'b00, 8'h00, 32'h11223344});
    end
    send_range(5, 8);
    total++;
    if ({boot_up, done, boot_web, boot_addr} !== {3'b100, 8'h01}) begin
      bad++;
      $display("FAIL normal_pre_csum got=%h need=%h", {boot_up, done, boot_web, boot_addr},
               {3'b100, 8'h01});
    end
    send_range(9, 9);
    total++;
    if ({boot_up, done, err, err_code} !== {3'b010, 2'b00}) begin
      bad++;
      $display("FAIL normal_status got=%b need=01000", {boot_up, done, err, err_code});
    end
    total++;
    if ({boot_addr, boot_datai} !== {8'h01, 32'hAABBCCDD}) begin
      bad++;
      $display("FAIL normal_hold got=%h need=01aabbccdd", {boot_addr, boot_datai});
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL normal_count got=%0d need=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL normal_write[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_csum();
    stim_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h47};
    build_expect();
    got_q.delete();
    pulse_start();
    send_range(0, stim_q.size() - 1);
    total++;
    if ({boot_up, done, err, err_code} !== {1'b1, 1'b0, 1'b1, exp_code}) begin
      bad++;
      $display("FAIL badcsum_status got=%b need=%b", {boot_up, done, err, err_code},
               {1'b1, 1'b0, 1'b1, exp_code});
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL badcsum_count got=%0d need=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL badcsum_write[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
      end
    end
    // Recovery with a fresh valid image
    gen_stream($urandom_range(1, 8), 1'b1);
    build_expect();
    got_q.delete();
    pulse_start();
    total++;
    if ({err, err_code} !== 3'b000) begin
      bad++;
      $display("FAIL recover_clear got=%b need=000", {err, err_code});
    end
    send_range(0, stim_q.size() - 1);
    total++;
    if ({done, err, err_code, boot_up} !== {exp_done, 1'b0, exp_code, 1'b0}) begin
      bad++;
      $display("FAIL recover_status got=%b need=%b", {done, err, err_code, boot_up},
               {exp_done, 1'b0, exp_code, 1'b0});
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL recover_count got=%0d need=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL recover_write[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    stim_q = '{8'h00};
    build_expect();
    got_q.delete();
    pulse_start();
    send_range(0, 0);
    total++;
    if ({err, err_code, done, boot_up} !== {1'b1, exp_code, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL zerolen_status got=%b need=%b", {err, err_code, done, boot_up},
               {1'b1, exp_code, 1'b0, 1'b1});
    end
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL zerolen_writes got=%0d need=0", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int long_at, start_at;
    gen_stream(255, 1'b1);
    build_expect();
    got_q.delete();
    start_at = stim_q.size() / 2;
    long_at  = int'($urandom_range(2, start_at - 2));
    pulse_start();
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == start_at) pulse_start();  // must be ignored mid-load
      send_byte(stim_q[i], (i == long_at) ? TIMEOUT - 1 : int'($urandom_range(0, 3)));
    end
    total++;
    if ({done, err, err_code, boot_up} !== {exp_done, 1'b0, exp_code, 1'b0}) begin
      bad++;
      $display("FAIL b2b_status got=%b need=%b", {done, err, err_code, boot_up},
               {exp_done, 1'b0, exp_code, 1'b0});
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got=%0d need=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_write[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    got_q.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early got=%b need=0", err);
    end
    @(negedge clk);
    total++;
    if ({err, err_code, boot_up, done} !== {1'b1, 2'b11, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL timeout_status got=%b need=11110", {err, err_code, boot_up, done});
    end
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_writes got=%0d need=0", got_q.size());
    end
    gen_stream(3, 1'b1);
    build_expect();
    pulse_start();
    send_range(0, stim_q.size() - 1);
    total++;
    if ({done, err, err_code} !== {exp_done, 1'b0, exp_code}) begin
      bad++;
      $display("FAIL timeout_resume got=%b need=%b", {done, err, err_code},
               {exp_done, 1'b0, exp_code});
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL timeout_resume_count got=%0d need=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL timeout_resume_write[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    gen_stream(3, 1'b1);
    got_q.delete();
    pulse_start();
    send_range(0, 9);  // two words written, first byte of the third taken
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, boot_up, boot_web, done, err, err_code} !== 7'b0010000) begin
      bad++;
      $display("FAIL arst_ctrl got=%b need=0010000",
               {in_ready, boot_up, boot_web, done, err, err_code});
    end
    total++;
    if ({boot_addr, boot_datai} !== '0) begin
      bad++;
      $display("FAIL arst_data got=%h need=0", {boot_addr, boot_datai});
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({in_ready, boot_up} !== 2'b00) begin
        bad++;
        $display("FAIL arst_idle got=%b need=00", {in_ready, boot_up});
      end
    end
    in_valid = 1'b0;
    gen_stream(2, 1'b1);
    build_expect();
    got_q.delete();
    pulse_start();
    send_range(0, stim_q.size() - 1);
    total++;
    if ({done, err} !== {exp_done, 1'b0}) begin
      bad++;
      $display("FAIL arst_reload got=%b need=%b", {done, err}, {exp_done, 1'b0});
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL arst_reload_count got=%0d need=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL arst_reload_write[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_bad_csum();
    test_zero_len();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_stream_loader.md
Name: boot_stream_loader

Overview:
- Upstream feeder for the pipelined CPU's boot port.
- Receives a byte stream (valid/ready) carrying a length header, big-endian 32-bit instruction words and an XOR checksum.
- Assembles each word and drives boot_up/boot_addr/boot_datai/boot_web to write instruction memory, one word per single-cycle write strobe.
- Holds the CPU in boot until the image is loaded and checked; reports done/error.

Parameters:
ADDR_W, 8, width of boot_addr; word index wraps modulo 2^ADDR_W
BASE_ADDR, 0, boot_addr of first word
TIMEOUT, 1023, idle cycles allowed between accepted bytes once a load has started

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin a load; honoured only in IDLE, DONE, ERR
in_valid  in  1  in_data valid
in_data  in  8  stream byte
in_ready  out  1  loader can accept a byte this cycle
boot_up  out  1  CPU held in boot mode
boot_addr  out  ADDR_W  instruction memory word address
boot_datai  out  32  instruction word
boot_web  out  1  write enable, active-low, one-cycle pulse per word
done  out  1  level, load passed checksum
err  out  1  level, load failed
err_code  out  2  01 checksum, 10 zero length, 11 timeout; 00 otherwise

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values (also asserted mid-operation, immediately): state IDLE, boot_up=0, boot_web=1, boot_addr=0, boot_datai=0, in_ready=0, done=0, err=0, err_code=00, all counters and checksum cleared.
- Byte transfer occurs only when in_valid && in_ready on a rising edge.
- in_ready=1 only in HDR, DATA and CSUM.
- States:
  - IDLE: start -> HDR; clears done, err, err_code and checksum; sets boot_up=1.
  - HDR: accept N. N=0 -> ERR (10). Otherwise store N, word_idx=0, byte_cnt=0 -> DATA. Header byte is XORed into the checksum.
  - DATA: accept bytes MSB first (1st byte -> [31:24], 4th byte -> [7:0]); each byte is XORed into the checksum. On the 4th byte -> WRITE.
  - WRITE (exactly 1 cycle): boot_web=0, boot_datai=assembled word, boot_addr=BASE_ADDR+word_idx (mod 2^ADDR_W), in_ready=0. Then word_idx++; if word_idx==N -> CSUM, else DATA.
  - CSUM: accept 1 byte. If byte == running XOR -> DONE, else ERR (01).
  - DONE: boot_up=0, done=1; start -> HDR (same as IDLE start).
  - ERR: boot_up stays 1 (CPU held), err=1, err_code latched; start -> HDR.
- boot_addr/boot_datai hold their last written values outside WRITE; boot_web=1 outside WRITE.
- Latency: boot_web falls the cycle after the 4th byte of a word is accepted; boot_up falls the cycle after the checksum byte is accepted.
- Timeout: a counter runs in HDR, DATA and CSUM. It resets on every accepted byte and on entry to HDR. When it reaches TIMEOUT -> ERR (11).
- Words already written before an error are not rolled back.
- start is ignored while in HDR, DATA, WRITE or CSUM.
- in_valid is ignored in IDLE, WRITE, DONE and ERR (byte not consumed).
- If start and rst coincide, rst wins.
- N counts words (1..255); the byte index rolls 3->0 after each word.

Test Plan:
- Normal load: start; bytes 02, 11 22 33 44, AA BB CC DD, 46 -> two WRITE pulses: addr 0/0x11223344, then addr 1/0xAABBCCDD; done=1, boot_up 1->0 one cycle after 0x46; err=0.
- Bad checksum: same stream with final byte 47 -> both words written; err=1, err_code=01, boot_up stays 1, done=0. Then start plus a valid stream -> done=1, err cleared.
- Zero length: start; byte 00 -> ERR (10) the next cycle; no boot_web pulse.
- Backpressure/gaps: in_valid toggled randomly with gaps <1023 cycles over a 255-word image -> 255 writes, addr 0..254 in order, data matching, done=1; in_ready=0 during every WRITE cycle.
- Timeout: start; 02, 11, then idle 1023 cycles -> err=1, err_code=11, no write issued; later start resumes from HDR.
- Async reset: assert rst during DATA between clock edges -> outputs return to reset values immediately; after release, loader sits in IDLE until start.
